// File: rtl/rtermcal_pkg.sv
// Shared definitions for the termination-calibration controller: FSM states,
// cell mode encodings and the thermometer encoder for the SGIO trim.
package rtermcal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SG_SET  = 3'd1,
        ST_SG_WAIT = 3'd2,
        ST_SG_EVAL = 3'd3,
        ST_LV_SET  = 3'd4,
        ST_LV_WAIT = 3'd5,
        ST_LV_EVAL = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_SGIO = 2'b01;
    localparam logic [1:0] MODE_LVDS = 2'b10;

    localparam logic [3:0] CODE_MAX = 4'd15;

    // Bit k of the result is set when k <= code, so code 0 drives no legs.
    function automatic logic [15:1] thermo15(input logic [3:0] code);
        logic [15:1] t;
        t = 15'b000_0000_0000_0000;
        for (int k = 1; k <= 15; k++) begin
            t[k] = (4'(k) <= code);
        end
        return t;
    endfunction

endpackage

// File: rtl/rtermcal_sync.sv
// Generic two-flop synchronizer, cleared to zero by reset.
module rtermcal_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/rtermcal_ctrl.sv
// Calibration sequencer for the 1.8 V IO termination cell: linear search of
// the SGIO thermometer trim, then a 4-bit SAR search of the LVDS trim.
module rtermcal_ctrl
    import rtermcal_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        CLK_I,
    input  logic        RSTN_I,
    input  logic        START_I,
    input  logic [1:0]  RESULT_I,
    output logic [1:0]  MODE_O,
    output logic [15:1] D_IOSG_O,
    output logic [3:0]  D_LVDS_O,
    output logic [3:0]  CODE_SGIO_O,
    output logic [3:0]  CODE_LVDS_O,
    output logic        BUSY_O,
    output logic        DONE_O,
    output logic [1:0]  ERR_O
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_e      state_r;
    logic [3:0]  sg_code_r;
    logic [3:0]  lv_code_r;
    logic [1:0]  bit_idx_r;
    logic [7:0]  cnt_r;
    logic [1:0]  mode_r;
    logic [15:1] d_iosg_r;
    logic [3:0]  d_lvds_r;
    logic [3:0]  code_sgio_r;
    logic [3:0]  code_lvds_r;
    logic        busy_r;
    logic        done_r;
    logic [1:0]  err_r;

    logic [1:0]  res_sync_s;
    logic [3:0]  trial_s;
    logic [3:0]  lv_next_s;
    logic [3:0]  sg_final_s;
    logic        sg_step_s;
    logic        sg_rail_s;

    rtermcal_sync #(
        .WIDTH (2)
    ) u_sync (
        .clk   (CLK_I),
        .rst_n (RSTN_I),
        .d     (RESULT_I),
        .q     (res_sync_s)
    );

    // SAR trial bit and the LVDS code kept after the current comparison
    always_comb begin
        trial_s   = 4'b0001 << bit_idx_r;
        lv_next_s = lv_code_r;
        if (res_sync_s[1] == 1'b0) begin
            lv_next_s = lv_code_r | trial_s;
        end else begin
            lv_next_s = lv_code_r;
        end
    end

    // SGIO ramp decision: keep stepping, or settle on a final code (and flag a rail)
    always_comb begin
        sg_step_s  = 1'b0;
        sg_rail_s  = 1'b0;
        sg_final_s = sg_code_r;
        if (res_sync_s[0] == 1'b0) begin
            if (sg_code_r == CODE_MAX) begin
                sg_rail_s  = 1'b1;
                sg_final_s = CODE_MAX;
            end else begin
                sg_step_s  = 1'b1;
                sg_final_s = sg_code_r;
            end
        end else begin
            if (sg_code_r == 4'd0) begin
                sg_rail_s  = 1'b1;
                sg_final_s = 4'd0;
            end else begin
                sg_final_s = sg_code_r - 4'd1;
            end
        end
    end

    // Calibration FSM with registered cell drive and result outputs
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_r     <= ST_IDLE;
            sg_code_r   <= 4'd0;
            lv_code_r   <= 4'd0;
            bit_idx_r   <= 2'd0;
            cnt_r       <= 8'd0;
            mode_r      <= MODE_OFF;
            d_iosg_r    <= 15'b000_0000_0000_0000;
            d_lvds_r    <= 4'd0;
            code_sgio_r <= 4'd0;
            code_lvds_r <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START_I) begin
                        sg_code_r <= 4'd0;
                        state_r   <= ST_SG_SET;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SG_SET: begin
                    mode_r   <= MODE_SGIO;
                    d_iosg_r <= thermo15(sg_code_r);
                    d_lvds_r <= 4'd0;
                    busy_r   <= 1'b1;
                    done_r   <= 1'b0;
                    err_r    <= 2'b00;
                    cnt_r    <= SETTLE_LOAD;
                    state_r  <= ST_SG_WAIT;
                end
                ST_SG_WAIT: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_SG_EVAL;
                    end else begin
                        cnt_r   <= cnt_r - 8'd1;
                    end
                end
                ST_SG_EVAL: begin
                    if (sg_step_s) begin
                        sg_code_r <= sg_code_r + 4'd1;
                        state_r   <= ST_SG_SET;
                    end else begin
                        code_sgio_r <= sg_final_s;
                        d_iosg_r    <= thermo15(sg_final_s);
                        err_r[0]    <= sg_rail_s;
                        lv_code_r   <= 4'd0;
                        bit_idx_r   <= 2'd3;
                        state_r     <= ST_LV_SET;
                    end
                end
                ST_LV_SET: begin
                    mode_r   <= MODE_LVDS;
                    d_lvds_r <= lv_code_r | trial_s;
                    cnt_r    <= SETTLE_LOAD;
                    state_r  <= ST_LV_WAIT;
                end
                ST_LV_WAIT: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_LV_EVAL;
                    end else begin
                        cnt_r   <= cnt_r - 8'd1;
                    end
                end
                ST_LV_EVAL: begin
                    lv_code_r <= lv_next_s;
                    if (bit_idx_r == 2'd0) begin
                        code_lvds_r <= lv_next_s;
                        d_lvds_r    <= lv_next_s;
                        err_r[1]    <= (lv_next_s == 4'd0) || (lv_next_s == CODE_MAX);
                        state_r     <= ST_DONE;
                    end else begin
                        bit_idx_r   <= bit_idx_r - 2'd1;
                        state_r     <= ST_LV_SET;
                    end
                end
                ST_DONE: begin
                    mode_r <= MODE_OFF;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    if (START_I) begin
                        sg_code_r <= 4'd0;
                        state_r   <= ST_SG_SET;
                    end else begin
                        state_r   <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign MODE_O      = mode_r;
    assign D_IOSG_O    = d_iosg_r;
    assign D_LVDS_O    = d_lvds_r;
    assign CODE_SGIO_O = code_sgio_r;
    assign CODE_LVDS_O = code_lvds_r;
    assign BUSY_O      = busy_r;
    assign DONE_O      = done_r;
    assign ERR_O       = err_r;

endmodule

// File: tb/tb_rtermcal_ctrl.sv
// Directed bench for rtermcal_ctrl: a behavioural termination cell whose
// comparators trip at SGIO count 11 and LVDS code 7, plus rail overrides.
module tb_rtermcal_ctrl;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [1:0]  force_sel = 2'd0;
    logic [1:0]  res1;
    logic [1:0]  res2 = 2'b00;

    logic [1:0]  mode1, mode2, err1, err2;
    logic [15:1] d_iosg1, d_iosg2;
    logic [3:0]  d_lvds1, d_lvds2, code_sg1, code_sg2, code_lv1, code_lv2;
    logic        busy1, busy2, done1, done2;

    int total = 0;
    int bad   = 0;
    int done_cyc;
    int mode_cyc;
    logic       done_at1;
    logic       busy_at1;
    logic [1:0] mode_at1;

    rtermcal_ctrl #(.SETTLE_CYCLES(16)) dut (
        .CLK_I(clk), .RSTN_I(rst_n), .START_I(start1), .RESULT_I(res1),
        .MODE_O(mode1), .D_IOSG_O(d_iosg1), .D_LVDS_O(d_lvds1),
        .CODE_SGIO_O(code_sg1), .CODE_LVDS_O(code_lv1),
        .BUSY_O(busy1), .DONE_O(done1), .ERR_O(err1)
    );

    rtermcal_ctrl #(.SETTLE_CYCLES(3)) dut_fast (
        .CLK_I(clk), .RSTN_I(rst_n), .START_I(start2), .RESULT_I(res2),
        .MODE_O(mode2), .D_IOSG_O(d_iosg2), .D_LVDS_O(d_lvds2),
        .CODE_SGIO_O(code_sg2), .CODE_LVDS_O(code_lv2),
        .BUSY_O(busy2), .DONE_O(done2), .ERR_O(err2)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] cell_model(input logic [1:0] mode, input logic [15:1] iosg,
                                              input logic [3:0] lvds);
        logic [1:0] r;
        r[0] = (mode == 2'b01) && ($countones(iosg) >= 11);
        r[1] = (mode == 2'b10) && (lvds >= 4'd7);
        return r;
    endfunction

    always_comb begin
        res1 = cell_model(mode1, d_iosg1, d_lvds1);
        case (force_sel)
            2'd1:    res1 = {res1[1], 1'b0};
            2'd2:    res1 = 2'b11;
            default: res1 = cell_model(mode1, d_iosg1, d_lvds1);
        endcase
    end

    // Slow comparator for the fast instance: bounces, then settles 13 ns after a code change
    always begin
        @(mode2 or d_iosg2 or d_lvds2);
        #4 res2 = ~cell_model(mode2, d_iosg2, d_lvds2);
        #9 res2 = cell_model(mode2, d_iosg2, d_lvds2);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse START on the slow instance and time DONE / the switch to LVDS mode.
    task automatic run1(input int pulse_at);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1   = 1'b0;
        done_cyc = 0;
        mode_cyc = 0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                done_at1 = done1;
                busy_at1 = busy1;
                mode_at1 = mode1;
            end
            if ((mode1 == 2'b10) && (mode_cyc == 0)) mode_cyc = cyc;
            start1 = (cyc == pulse_at);
            if (done1) begin
                done_cyc = cyc;
                break;
            end
        end
        start1 = 1'b0;
    endtask

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        #20;
        chk("reset_outputs", {mode1, d_iosg1, d_lvds1, code_sg1, code_lv1, busy1, done1, err1}, 64'd0);
        chk("reset_outputs_fast", {mode2, d_iosg2, d_lvds2, code_sg2, code_lv2, busy2, done2, err2}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // nominal run
        run1(0);
        chk("nom_busy_at1", busy_at1, 1);
        chk("nom_mode_at1", mode_at1, 2'b01);
        chk("nom_done_cycles", done_cyc, 289);
        chk("nom_lvds_mode_cycle", mode_cyc, 217);
        chk("nom_code_sgio", code_sg1, 10);
        chk("nom_d_iosg", d_iosg1, 15'h03FF);
        chk("nom_code_lvds", code_lv1, 6);
        chk("nom_d_lvds", d_lvds1, 6);
        chk("nom_err", err1, 2'b00);
        @(posedge clk);
        #1;
        chk("nom_done_mode", mode1, 2'b00);
        chk("nom_done_busy", busy1, 0);

        // restart from DONE with an ignored START during SG_WAIT
        repeat (3) @(negedge clk);
        run1(5);
        chk("restart_done_cleared", done_at1, 0);
        chk("restart_done_cycles", done_cyc, 289);
        chk("restart_code_sgio", code_sg1, 10);
        chk("restart_code_lvds", code_lv1, 6);
        chk("restart_err", err1, 2'b00);

        // SGIO top rail
        force_sel = 2'd1;
        run1(0);
        chk("top_code_sgio", code_sg1, 15);
        chk("top_d_iosg", d_iosg1, 15'h7FFF);
        chk("top_err", err1, 2'b01);
        chk("top_sg_phase_cycles", mode_cyc, 289);
        chk("top_done_cycles", done_cyc, 361);
        chk("top_code_lvds", code_lv1, 6);

        // both bottom rails
        force_sel = 2'd2;
        run1(0);
        chk("bot_code_sgio", code_sg1, 0);
        chk("bot_code_lvds", code_lv1, 0);
        chk("bot_d_iosg", d_iosg1, 15'h0000);
        chk("bot_err", err1, 2'b11);
        chk("bot_done_cycles", done_cyc, 91);

        // reset during LV_WAIT
        force_sel = 2'd0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (mode1 == 2'b10) break;
        end
        chk("mid_reached_lvds", mode1, 2'b10);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {mode1, d_iosg1, d_lvds1, code_sg1, code_lv1, busy1, done1, err1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run1(0);
        chk("post_reset_done_cycles", done_cyc, 289);
        chk("post_reset_code_sgio", code_sg1, 10);
        chk("post_reset_code_lvds", code_lv1, 6);
        chk("post_reset_err", err1, 2'b00);

        // minimum settle with a bouncing, late comparator
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2   = 1'b0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                done_cyc = cyc;
                break;
            end
        end
        chk("fast_done_cycles", done_cyc, 81);
        chk("fast_code_sgio", code_sg2, 10);
        chk("fast_d_iosg", d_iosg2, 15'h03FF);
        chk("fast_code_lvds", code_lv2, 6);
        chk("fast_err", err2, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
